// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory interface: default widths, write-protect base
// and the access sequencer state encoding.
package mem_if_pkg;

  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 16;
  localparam int WPROT_BASE_DEF = 21;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: IDLE -> SETUP -> STROBE -> DONE, all outputs registered.
// Optional write protection above WPROT_BASE is enabled by defining MEMCTRL_WPROT_EN.
//
// state  | meaning
// IDLE   | waiting for req; address/data from the last access stay on the bus
// SETUP  | address and write data driven, strobes low
// STROBE | rd or wr high for STROBE_CYCLES cycles; down-counter tracks the remaining cycles
// DONE   | ack (and err for a protected write) pulse, strobes low
module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int STROBE_CYCLES = 1,
  parameter int WPROT_BASE    = WPROT_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int          CNT_W    = 2;
  localparam [CNT_W-1:0]  CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   in_d, rdata_d;
  logic                busy_d, ack_d, err_d, rd_d, wr_d;
  logic                prot_hit;

`ifdef MEMCTRL_WPROT_EN
  // mem_addr holds the latched address for the whole access, so this is stable
  assign prot_hit = we_q && (mem_addr >= ADDR_W'(WPROT_BASE));
`else
  assign prot_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      mem_addr <= '0;
      mem_in   <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      mem_addr <= addr_d;
      mem_in   <= in_d;
      rdata    <= rdata_d;
      busy     <= busy_d;
      ack      <= ack_d;
      err      <= err_d;
      mem_rd   <= rd_d;
      mem_wr   <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = mem_addr;
    in_d    = mem_in;
    rdata_d = rdata;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          in_d    = wdata;
          we_d    = we;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = CNT_LOAD;
        rd_d    = !we_q;
        wr_d    = we_q && !prot_hit;
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          err_d   = prot_hit;
          if (!we_q) rdata_d = mem_out;
        end else begin
          cnt_d = cnt_q - 1'b1;
          rd_d  = mem_rd;
          wr_d  = mem_wr;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with STROBE_CYCLES=1 and one with 3,
// each attached to its own small memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        req = 1'b0, we = 1'b0;
  logic [4:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        busy, ack, err, mem_rd, mem_wr;
  logic [15:0] rdata, mem_in, mem_out;
  logic [4:0]  mem_addr;

  logic        req3 = 1'b0, we3 = 1'b0;
  logic [4:0]  addr3 = '0;
  logic [15:0] wdata3 = '0;
  logic        busy3, ack3, err3, mem_rd3, mem_wr3;
  logic [15:0] rdata3, mem_in3, mem_out3;
  logic [4:0]  mem_addr3;

  logic [15:0] mem  [32];
  logic [15:0] mem3 [32];

  int total = 0;
  int bad   = 0;

  int r_rd_n, r_rd_first, r_rd_rise, r_wr_n, r_wr_first, r_ack_at, r_acks, r_err, r_both;
  logic [15:0] r_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(.STROBE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .rdata(rdata), .err(err), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_in(mem_in), .mem_out(mem_out)
  );

  mem_access_ctrl #(.STROBE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .busy(busy3), .ack(ack3), .rdata(rdata3), .err(err3), .mem_addr(mem_addr3),
    .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_in(mem_in3), .mem_out(mem_out3)
  );

  assign mem_out  = mem[mem_addr];
  assign mem_out3 = mem3[mem_addr3];

  always @(posedge clk) begin
    if (mem_wr)  mem[mem_addr]   <= mem_in;
    if (mem_wr3) mem3[mem_addr3] <= mem_in3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, then watch 12 cycles (cycle 1 = the cycle after the accept edge).
  task automatic acc(input bit s3, input logic w, input logic [4:0] a, input logic [15:0] d,
                     input bit poke);
    logic rd, wr, ak, er, rd_prev;
    @(posedge clk); #1;
    if (s3) begin req3 = 1'b1; we3 = w; addr3 = a; wdata3 = d; end
    else    begin req  = 1'b1; we  = w; addr  = a; wdata  = d; end
    @(posedge clk); #1;
    req = 1'b0; req3 = 1'b0;
    r_rd_n = 0; r_rd_first = 0; r_rd_rise = 0; r_wr_n = 0; r_wr_first = 0;
    r_ack_at = 0; r_acks = 0; r_err = 0; r_both = 0; r_rdata = 'x;
    rd_prev = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      rd = s3 ? mem_rd3 : mem_rd;
      wr = s3 ? mem_wr3 : mem_wr;
      ak = s3 ? ack3 : ack;
      er = s3 ? err3 : err;
      if (rd) begin r_rd_n++; if (r_rd_first == 0) r_rd_first = c; end
      if (rd && !rd_prev) r_rd_rise++;
      rd_prev = rd;
      if (wr) begin r_wr_n++; if (r_wr_first == 0) r_wr_first = c; end
      if (rd && wr) r_both++;
      if (er) r_err++;
      if (ak) begin
        r_acks++;
        if (r_ack_at == 0) begin
          r_ack_at = c;
          r_rdata  = s3 ? rdata3 : rdata;
        end
      end
      if (poke && c == 2) req3 = 1'b1;
      if (poke && c == 3) req3 = 1'b0;
    end
  endtask

  initial begin
    int ack_a, ack_b, rises;
    logic rd_prev;
    logic [15:0] rd_a, rd_b;

    for (int i = 0; i < 32; i++) begin mem[i] = '0; mem3[i] = '0; end
    mem[0] = 16'd3; mem[1] = 16'h0011; mem[2] = 16'd3; mem[22] = 16'h5555;
    mem3[0] = 16'd3; mem3[1] = 16'h0011; mem3[2] = 16'd3; mem3[22] = 16'h5555;

    // reset state
    #1 rst_n = 1'b0;
    #10;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mrd", mem_rd, 0);
    chk("rst_mwr", mem_wr, 0);
    chk("rst_min", mem_in, 0);
    @(negedge clk) rst_n = 1'b1;

    // read addr 0
    acc(1'b0, 1'b0, 5'd0, 16'h0, 1'b0);
    chk("rd0_first", r_rd_first, 2);
    chk("rd0_len", r_rd_n, 1);
    chk("rd0_wr", r_wr_n, 0);
    chk("rd0_ack_at", r_ack_at, 3);
    chk("rd0_acks", r_acks, 1);
    chk("rd0_rdata", r_rdata, 16'd3);
    chk("rd0_err", r_err, 0);
    chk("rd0_busy_idle", busy, 0);

    // write addr 5
    acc(1'b0, 1'b1, 5'd5, 16'hBEEF, 1'b0);
    chk("wr5_first", r_wr_first, 2);
    chk("wr5_len", r_wr_n, 1);
    chk("wr5_rd", r_rd_n, 0);
    chk("wr5_ack_at", r_ack_at, 3);
    chk("wr5_rdata_kept", rdata, 16'd3);
    chk("wr5_mem", mem[5], 16'hBEEF);
    chk("wr5_addr_held", mem_addr, 5);
    chk("wr5_in_held", mem_in, 16'hBEEF);

    // read back addr 5
    acc(1'b0, 1'b0, 5'd5, 16'h0, 1'b0);
    chk("rd5_rdata", r_rdata, 16'hBEEF);
    chk("rd5_ack_at", r_ack_at, 3);

    // STROBE_CYCLES=3 read of addr 2, with a req poked while busy
    acc(1'b1, 1'b0, 5'd2, 16'h0, 1'b1);
    chk("s3_first", r_rd_first, 2);
    chk("s3_len", r_rd_n, 3);
    chk("s3_rises", r_rd_rise, 1);
    chk("s3_ack_at", r_ack_at, 5);
    chk("s3_acks", r_acks, 1);
    chk("s3_rdata", r_rdata, 16'd3);

    // write to addr 22 (protected only with the feature)
    acc(1'b0, 1'b1, 5'd22, 16'h1234, 1'b0);
    chk("wp_ack_at", r_ack_at, 3);
`ifdef MEMCTRL_WPROT_EN
    chk("wp_wr", r_wr_n, 0);
    chk("wp_err", r_err, 1);
`else
    chk("wp_wr", r_wr_n, 1);
    chk("wp_err", r_err, 0);
`endif
    acc(1'b0, 1'b0, 5'd22, 16'h0, 1'b0);
`ifdef MEMCTRL_WPROT_EN
    chk("wp_rd22", r_rdata, 16'h5555);
`else
    chk("wp_rd22", r_rdata, 16'h1234);
`endif
    chk("wp_rd_err", r_err, 0);

    // back-to-back reads with req held high
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 5'd0;
    @(posedge clk); #1;
    addr = 5'd1;
    ack_a = 0; ack_b = 0; rises = 0; rd_prev = 1'b0; rd_a = 'x; rd_b = 'x;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_rd && !rd_prev) rises++;
      rd_prev = mem_rd;
      if (ack) begin
        if (ack_a == 0) begin ack_a = c; rd_a = rdata; end
        else if (ack_b == 0) begin ack_b = c; rd_b = rdata; end
      end
      if (c == 5) req = 1'b0;
    end
    chk("b2b_rises", rises, 2);
    chk("b2b_ack_a", ack_a, 3);
    chk("b2b_ack_b", ack_b, 7);
    chk("b2b_rdata_a", rd_a, 16'd3);
    chk("b2b_rdata_b", rd_b, 16'h0011);

    // reset in the middle of a write strobe
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 5'd7; wdata = 16'h7777;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_wr_high", mem_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wr_drop", mem_wr, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ack", ack, 0);
    chk("mid_rdata", rdata, 0);
    chk("mid_maddr", mem_addr, 0);
    chk("mid_min", mem_in, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    ack_a = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack || busy || mem_wr) ack_a++;
    end
    chk("mid_quiet", ack_a, 0);
    chk("mid_mem7", mem[7], 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
